// File: rtl/shift_pkg.sv
// Shared definitions for the iterative and combinational shifter blocks.
// Holds FSM state encoding, default widths and shift-op codes.
package shift_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_SHAMT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10
   } shift_op_t;

endpackage

// File: rtl/lsl1_step.sv
// Single-bit left shift step: next data, bit shifted out of the MSB,
// and whether this step flips the sign bit.
module lsl1_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] nxt,
   output logic             carry,
   output logic             ovf_bit
);

   assign nxt     = {d[WIDTH-2:0], 1'b0};
   assign carry   = d[WIDTH-1];
   assign ovf_bit = d[WIDTH-1] ^ d[WIDTH-2];

endmodule

// File: rtl/lsl8_seq.sv
// Iterative shift-left unit, one bit per clock under start/done.
// Tracks last carry out and sticky signed overflow.
module lsl8_seq
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   d_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   d_out,
   output logic               c_out,
   output logic               ovf,
   output logic               busy,
   output logic               done
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   d_reg;
   logic [SHAMT_W-1:0] cnt;
   logic               c_reg;
   logic               ovf_reg;

   logic [WIDTH-1:0]   step_d;
   logic               step_c;
   logic               step_ovf;

   lsl1_step #(.WIDTH(WIDTH)) u_step (
      .d       (d_reg),
      .nxt     (step_d),
      .carry   (step_c),
      .ovf_bit (step_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (shamt != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            if (cnt == SHAMT_W'(1))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         SHIFT: busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: capture on accepted start, step while shifting, else hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_reg   <= '0;
         cnt     <= '0;
         c_reg   <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  d_reg   <= d_in;
                  cnt     <= shamt;
                  c_reg   <= 1'b0;
                  ovf_reg <= 1'b0;
               end
            end
            SHIFT: begin
               d_reg   <= step_d;
               c_reg   <= step_c;
               ovf_reg <= ovf_reg | step_ovf;
               cnt     <= cnt - SHAMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign d_out = d_reg;
   assign c_out = c_reg;
   assign ovf   = ovf_reg;

endmodule

// File: doc/lsl8_seq.md
Name: lsl8_seq

Overview:
- Iterative 8-bit logical/arithmetic shift-left unit; the left-direction counterpart to the team's combinational arithmetic shift-right block.
- Shifts one bit per clock under a start/done handshake.
- Reports the last bit shifted out (carry) and signed overflow.
- Sits beside the combinational shifters in the datapath for multi-cycle ALU operations.

Parameters:
- WIDTH, 8, data width in bits.
- SHAMT_W, 3, shift-amount width; legal shift amounts are 0 to 2^SHAMT_W-1, i.e. 0..7.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- d_in  input  WIDTH  operand; captured when start is accepted
- shamt  input  SHAMT_W  shift amount; captured when start is accepted
- d_out  output  WIDTH  shift register contents; final result while done=1
- c_out  output  1  last bit shifted out of the MSB; 0 if shamt=0
- ovf  output  1  sticky signed overflow: set if the sign bit changed on any shift step
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; result valid in that cycle

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; d_out=0, c_out=0, ovf=0, busy=0, done=0; counter=0.
  - Reset takes effect immediately, including mid-shift; no partial result is kept.
- IDLE:
  - start=1 at an edge: d_reg<=d_in, cnt<=shamt, c_out<=0, ovf<=0.
  - Next state is SHIFT if shamt!=0, else DONE.
  - start=0: hold. d_out keeps the last result.
- SHIFT, each edge:
  - d_reg <= {d_reg[WIDTH-2:0],1'b0}; c_out <= d_reg[WIDTH-1].
  - ovf <= ovf | (d_reg[WIDTH-1]^d_reg[WIDTH-2]).
  - cnt <= cnt-1.
  - When cnt==1, next state is DONE; otherwise stay in SHIFT.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
  - d_out, c_out and ovf hold the final values until the next accepted start.
- Latency: done is high in the cycle after edge number shamt+1, counted from the edge that sampled start.
  - shamt=0: 1 edge.
  - shamt=7: 8 edges.
- start while busy=1 is ignored; no queuing. start may be asserted in the DONE cycle and is still ignored; it is accepted on the first IDLE edge.
- shamt=0: d_out=d_in, c_out=0, ovf=0.
- Shift counts of WIDTH or more cannot occur because SHAMT_W = log2(WIDTH).
- d_in and shamt changing during SHIFT have no effect.
- done, busy and ovf are registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package shift_pkg:
  - state enum IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - WIDTH/SHAMT_W defaults.
  - Shift-op encodings, reusable by the ASR/LSR blocks.
- One natural sub-module, lsl1_step: combinational single-bit left step producing next data, shifted-out bit and overflow bit.
- FSM and counter stay in lsl8_seq.

Test Plan:
- Reset mid-operation: start d_in=8'b0101_1001, shamt=3; pulse reset_n low after 2 edges -> outputs are all 0 immediately, state IDLE; a subsequent start works normally.
- d_in=8'b0101_1001, shamt=0 -> done after 1 edge; d_out=8'b0101_1001, c_out=0, ovf=0.
- d_in=8'b0101_1001, shamt=1 -> done after 2 edges; d_out=8'b1011_0010, c_out=0, ovf=1.
- d_in=8'b0101_1001, shamt=2 -> d_out=8'b0110_0100, c_out=1, ovf=1; shamt=3 -> d_out=8'b1100_1000, c_out=0, ovf=1.
- d_in=8'b1011_1011, shamt=7 -> done after 8 edges; d_out=8'b1000_0000, c_out=1, ovf=1; busy high for 8 cycles.
- Handshake: hold start=1 continuously with d_in=8'h01, shamt=1 -> d_out=8'h02, done pulses exactly once per operation; a second start in the DONE cycle is ignored and is accepted on the next IDLE edge; done is never high two cycles in a row.
